// File: rtl/apu_pkg.sv
// Shared step-table constants and types for the frame sequencer.
// FRAME_IRQ_EN selects whether the frame interrupt flag is built.
package apu_pkg;

  typedef logic [2:0] step_t;

  // Bit n of each mask marks the pulse issued when step n ticks.
  localparam logic [4:0] QMASK4 = 5'b01111;
  localparam logic [4:0] HMASK4 = 5'b01010;
  localparam logic [4:0] QMASK5 = 5'b10111;
  localparam logic [4:0] HMASK5 = 5'b10010;

  localparam int MODE_FIVE = 1;
  localparam int MODE_INH  = 0;

  localparam step_t LAST4 = 3'd3;
  localparam step_t LAST5 = 3'd4;
  localparam step_t IRQ_STEP = 3'd3;

endpackage

// File: rtl/frame_prescaler.sv
// Divides clk down to the sequencer step rate.
// tick is high on the last count of each QDIV-cycle period.
module frame_prescaler #(
  parameter int QDIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int W = $clog2(QDIV);

  logic [W-1:0] r_cnt;

  assign tick = (r_cnt == W'(QDIV - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// Quarter/half-frame enable generator with 4-step and 5-step modes.
// Define FRAME_IRQ_EN to build the frame interrupt flag.
module frame_sequencer
  import apu_pkg::*;
#(
  parameter int CLK_HZ  = 12_000_000,
  parameter int STEP_HZ = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_wr,
  input  logic [1:0] mode_data,
  input  logic       irq_ack,
  output logic       enable_240hz,
  output logic       enable_120hz,
  output logic       frame_irq,
  output logic [2:0] step,
  output logic       five_step_mode
);

  localparam int QDIV = CLK_HZ / STEP_HZ;

  logic       w_tick;
  logic [4:0] w_qm;
  logic [4:0] w_hm;
  logic       w_last;
  step_t      r_step;
  logic       r_five;
  logic       r_q;
  logic       r_h;

  frame_prescaler #(.QDIV(QDIV)) u_pre (
    .clk  (clk),
    .reset(reset),
    .clear(mode_wr),
    .tick (w_tick)
  );

  assign w_qm   = r_five ? QMASK5 : QMASK4;
  assign w_hm   = r_five ? HMASK5 : HMASK4;
  assign w_last = (r_step == (r_five ? LAST5 : LAST4));

  // A mode write restarts the frame and swallows any coincident tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_step <= '0;
      r_five <= 1'b0;
      r_q    <= 1'b0;
      r_h    <= 1'b0;
    end else begin
      r_q <= 1'b0;
      r_h <= 1'b0;
      if (mode_wr) begin
        r_five <= mode_data[MODE_FIVE];
        r_step <= '0;
        if (mode_data[MODE_FIVE]) begin
          r_q <= 1'b1;
          r_h <= 1'b1;
        end
      end else if (w_tick) begin
        r_q    <= w_qm[r_step];
        r_h    <= w_hm[r_step];
        r_step <= w_last ? '0 : r_step + 3'd1;
      end
    end
  end

`ifdef FRAME_IRQ_EN
  logic r_inh;
  logic r_irq;
  logic w_set;
  logic w_clr;

  assign w_set = w_tick & ~mode_wr & ~r_five & ~r_inh
               & (r_step == IRQ_STEP);
  assign w_clr = irq_ack | (mode_wr & mode_data[MODE_INH]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_inh <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (mode_wr) begin
        r_inh <= mode_data[MODE_INH];
      end
      if (w_set) begin
        r_irq <= 1'b1;
      end else if (w_clr) begin
        r_irq <= 1'b0;
      end
    end
  end

  assign frame_irq = r_irq;
`else
  logic w_unused;
  assign w_unused  = ^{irq_ack, mode_data[MODE_INH]};
  assign frame_irq = 1'b0;
`endif

  assign enable_240hz   = r_q;
  assign enable_120hz   = r_h;
  assign step           = r_step;
  assign five_step_mode = r_five;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer at QDIV = 4.
// Frame-irq expectations follow FRAME_IRQ_EN.
module tb_frame_sequencer;

`ifdef FRAME_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mode_wr = 1'b0;
  logic [1:0] mode_data = 2'b00;
  logic       irq_ack = 1'b0;
  logic       enable_240hz;
  logic       enable_120hz;
  logic       frame_irq;
  logic [2:0] step;
  logic       five_step_mode;

  int checks = 0;
  int errors = 0;

  frame_sequencer #(.CLK_HZ(960), .STEP_HZ(240)) dut (
    .clk           (clk),
    .reset         (reset),
    .mode_wr       (mode_wr),
    .mode_data     (mode_data),
    .irq_ack       (irq_ack),
    .enable_240hz  (enable_240hz),
    .enable_120hz  (enable_120hz),
    .frame_irq     (frame_irq),
    .step          (step),
    .five_step_mode(five_step_mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       mwr;
    logic [1:0] md;
    logic       ack;
    logic [6:0] exp;
  } vec_t;

  vec_t v4[16];
  vec_t v5[26];

  function automatic logic [6:0] pk(input logic q, input logic h,
                                    input logic i, input int s,
                                    input logic f);
    pk = {q, h, i, 3'(s), f};
  endfunction

  function automatic logic [6:0] outs();
    outs = {enable_240hz, enable_120hz, frame_irq, step, five_step_mode};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) clk1();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mode_wr = 1'b0;
    mode_data = 2'b00;
    irq_ack = 1'b0;
    clk1();
    reset = 1'b0;
  endtask

  task automatic apply(input vec_t v, input string nm, input int n);
    mode_wr = v.mwr;
    mode_data = v.md;
    irq_ack = v.ack;
    clk1();
    mode_wr = 1'b0;
    irq_ack = 1'b0;
    chk($sformatf("%s[%0d]", nm, n), 32'(outs()), 32'(v.exp));
  endtask

  initial begin
    int bad;
    int m;

    for (int n = 1; n <= 16; n++) begin
      v4[n-1].mwr = 1'b0;
      v4[n-1].md  = 2'b00;
      v4[n-1].ack = 1'b0;
      v4[n-1].exp = pk(n % 4 == 0, n % 8 == 0, IRQ_EN && n >= 16,
                       (n / 4) % 4, 1'b0);
    end

    for (int n = 1; n <= 26; n++) begin
      m = n - 6;
      v5[n-1].mwr = (n == 6);
      v5[n-1].md  = (n == 6) ? 2'b10 : 2'b00;
      v5[n-1].ack = 1'b0;
      if (n < 6)
        v5[n-1].exp = pk(n == 4, 1'b0, 1'b0, n >= 4 ? 1 : 0, 1'b0);
      else
        v5[n-1].exp = pk(n == 6 || (m > 0 && m % 4 == 0 && m != 16),
                         n == 6 || m == 8 || m == 20, 1'b0,
                         (m / 4) % 5, 1'b1);
    end

    // Reset state
    run(2);
    do_reset();
    chk("reset_outs", 32'(outs()), 32'h0);

    foreach (v4[i]) apply(v4[i], "four_step", i + 1);

    do_reset();
    foreach (v5[i]) apply(v5[i], "five_step", i + 1);

`ifdef FRAME_IRQ_EN
    do_reset();
    run(15);
    irq_ack = 1'b1;
    clk1();
    irq_ack = 1'b0;
    chk("irq_set_wins", 32'(frame_irq), 32'h1);
    clk1();
    chk("irq_hold", 32'(frame_irq), 32'h1);
    irq_ack = 1'b1;
    clk1();
    irq_ack = 1'b0;
    chk("irq_ack_clr", 32'(frame_irq), 32'h0);
    run(14);
    chk("irq_reset2", 32'(frame_irq), 32'h1);
    mode_wr = 1'b1;
    mode_data = 2'b01;
    clk1();
    mode_wr = 1'b0;
    mode_data = 2'b00;
    chk("irq_inh_clr", 32'(frame_irq), 32'h0);
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      clk1();
      if (frame_irq !== 1'b0) bad++;
    end
    chk("irq_inh_hold", 32'(bad), 32'h0);
`else
    do_reset();
    bad = 0;
    for (int n = 1; n <= 64; n++) begin
      clk1();
      if (enable_240hz !== (n % 4 == 0) || enable_120hz !== (n % 8 == 0)
          || frame_irq !== 1'b0)
        bad++;
    end
    chk("noirq_64", 32'(bad), 32'h0);
`endif

    do_reset();
    run(3);
    mode_wr = 1'b1;
    mode_data = 2'b00;
    clk1();
    mode_wr = 1'b0;
    chk("wr_on_tick", 32'(outs()), 32'h0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      clk1();
      if (enable_240hz !== 1'b0) bad++;
    end
    chk("wr_tick_quiet", 32'(bad), 32'h0);
    clk1();
    chk("wr_tick_nextq", 32'(outs()), 32'(pk(1'b1, 1'b0, 1'b0, 1, 1'b0)));

    do_reset();
    run(7);
    reset = 1'b1;
    mode_wr = 1'b1;
    mode_data = 2'b10;
    clk1();
    reset = 1'b0;
    mode_wr = 1'b0;
    mode_data = 2'b00;
    chk("rst_mid", 32'(outs()), 32'h0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      clk1();
      if (enable_240hz !== 1'b0) bad++;
    end
    chk("rst_quiet", 32'(bad), 32'h0);
    clk1();
    chk("rst_resume", 32'(outs()), 32'(pk(1'b1, 1'b0, 1'b0, 1, 1'b0)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
